// File: rtl/mod3_serial_sched.sv
// mod3_serial_sched: round-robin scheduler in front of one bit-serial mod-3 residue engine.
// Ports:
//   clk, reset                               clock and synchronous active-high reset
//   req_valid_i, req_data_i, req_ready_o     per-requester word handshake (ready is one-hot)
//   res_valid_o, res_ready_i                 result handshake
//   res_id_o, res_rem_o, res_div_o           result tag, remainder mod 3, divisible flag
//   busy_o                                   engine occupied (shifting or holding a result)
module mod3_serial_sched #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      res_valid_o,
    input  logic                      res_ready_i,
    output logic [ID_W-1:0]           res_id_o,
    output logic [1:0]                res_rem_o,
    output logic                      res_div_o,
    output logic                      busy_o
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [ID_W-1:0]  ID_RST   = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [DATA_W-1:0]   shreg;
    logic [CNT_W-1:0]    cnt;
    logic [1:0]          residue;
    logic [ID_W-1:0]     res_id;
    logic [ID_W-1:0]     last_grant;

    logic                hi_found;
    logic                lo_found;
    logic [ID_W-1:0]     hi_id;
    logic [ID_W-1:0]     lo_id;
    logic                gnt_any;
    logic [ID_W-1:0]     gnt_id;
    logic [NUM_REQ-1:0]  gnt_onehot;
    logic [DATA_W-1:0]   gnt_data;

    // r' = (2r + b) mod 3; the unused code 2'b11 behaves like residue 0.
    function automatic logic [1:0] mod3_step(input logic [1:0] r, input logic b);
        logic [1:0] n;
        case (r)
            2'd1:    n = b ? 2'd0 : 2'd2;
            2'd2:    n = b ? 2'd2 : 2'd1;
            default: n = {1'b0, b};
        endcase
        return n;
    endfunction

    // Round-robin: prefer the lowest valid index above last_grant,
    // otherwise wrap to the lowest valid index at or below it.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[k]) begin
                if (ID_W'(k) > last_grant) begin
                    hi_found = 1'b1;
                    hi_id    = ID_W'(k);
                end else begin
                    lo_found = 1'b1;
                    lo_id    = ID_W'(k);
                end
            end
        end
        gnt_any = hi_found | lo_found;
        gnt_id  = hi_found ? hi_id : lo_id;
    end

    always_comb begin
        gnt_onehot = '0;
        gnt_data   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_any && (ID_W'(k) == gnt_id)) begin
                gnt_onehot[k] = 1'b1;
                gnt_data      = req_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (gnt_any) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_LAST) state_nxt = DONE;
            DONE:    if (res_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on grant, shift MSB-first through the residue engine
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg      <= '0;
            cnt        <= '0;
            residue    <= 2'd0;
            res_id     <= '0;
            last_grant <= ID_RST;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        shreg      <= gnt_data;
                        res_id     <= gnt_id;
                        residue    <= 2'd0;
                        cnt        <= '0;
                        last_grant <= gnt_id;
                    end
                end
                SHIFT: begin
                    residue <= mod3_step(residue, shreg[DATA_W-1]);
                    shreg   <= shreg << 1;
                    cnt     <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        req_ready_o = '0;
        res_valid_o = 1'b0;
        res_rem_o   = 2'd0;
        res_div_o   = 1'b0;
        busy_o      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!reset) req_ready_o = gnt_onehot;
            end
            SHIFT: begin
                busy_o = 1'b1;
            end
            DONE: begin
                busy_o      = 1'b1;
                res_valid_o = 1'b1;
                res_rem_o   = residue;
                res_div_o   = (residue == 2'd0);
            end
            default: ;
        endcase
    end

    assign res_id_o = res_id;

endmodule
